// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic units (divider and multiplier).
// Holds the FSM state encoding and the iteration counter sizing helper.
package seq_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TEST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 16;

    // Bits needed to count operand bit positions 0..width-1.
    function automatic int count_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider: operands and start in, status and results out.
interface seq_divider_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_datapath.sv
// Restoring-division datapath: operand, partial-remainder and quotient registers,
// the WIDTH+1-bit trial subtractor and the registered result outputs.
module divider_datapath
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = count_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic             test_en,
    input  logic             last,
    input  logic [CW-1:0]    count,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH:0]   prem_q;
    logic [WIDTH:0]   prem_nxt;
    logic [WIDTH:0]   trial;
    logic [CW-1:0]    bit_idx;
    logic             trial_neg;

    // Partial remainder stays below 2*divisor, so WIDTH+1 bits carry both the value and the sign of the trial.
    assign bit_idx   = CW'(WIDTH - 1) - count;
    assign trial     = prem_q - {1'b0, dvs_q};
    assign trial_neg = trial[WIDTH];

    always_comb begin
        quo_nxt          = quo_q;
        quo_nxt[bit_idx] = ~trial_neg;
        prem_nxt         = trial_neg ? prem_q : trial;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            prem_q      <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (load) begin
                dvd_q       <= dividend;
                dvs_q       <= divisor;
                prem_q      <= '0;
                quo_q       <= '0;
                div_by_zero <= (divisor == '0);
                if (divisor == '0) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end
            end
            if (shift_en) begin
                prem_q <= {prem_q[WIDTH-1:0], dvd_q[bit_idx]};
            end
            if (test_en) begin
                prem_q <= prem_nxt;
                quo_q  <= quo_nxt;
                if (last) begin
                    quotient  <= quo_nxt;
                    remainder <= prem_nxt[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per SHIFT/TEST pair,
// fixed latency of 2*WIDTH+1 cycles, immediate completion on a zero divisor.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on the accepting edge
//   SHIFT | bring next dividend bit into the partial remainder
//   TEST  | trial subtract, set quotient bit, advance bit counter
//   DONE  | results valid, one-cycle done pulse
module seq_divider
    import seq_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    localparam int CW = count_width(WIDTH);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic          last;
    logic          load;
    logic          shift_en;
    logic          test_en;

    assign last = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                count <= '0;
            end else if (test_en) begin
                count <= last ? '0 : count + CW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = (bus.divisor == '0) ? DONE : SHIFT;
            SHIFT:   state_nxt = TEST;
            TEST:    state_nxt = last ? DONE : SHIFT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
        load     = (state == IDLE) && bus.start;
        shift_en = (state == SHIFT);
        test_en  = (state == TEST);
    end

    divider_datapath #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .shift_en    (shift_en),
        .test_en     (test_en),
        .last        (last),
        .count       (count),
        .dividend    (bus.dividend),
        .divisor     (bus.divisor),
        .quotient    (bus.quotient),
        .remainder   (bus.remainder),
        .div_by_zero (bus.div_by_zero)
    );

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): latency/arithmetic model checked
// every cycle, plus directed cases with literal expected results.
module tb_seq_divider;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request finishes a fixed number of cycles later with a/b, a%b.
    bit         m_act = 1'b0;
    int         m_cyc = 0;
    int         m_lat = 0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic       m_dbz = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_act = 1'b0; m_cyc = 0; m_lat = 0;
            m_q = '0; m_r = '0; m_dbz = 1'b0;
        end else if (!m_act) begin
            if (bus.start) begin
                m_act = 1'b1;
                m_cyc = 1;
                if (bus.divisor == 0) begin
                    m_lat = 1; p_q = '1; p_r = bus.dividend; m_dbz = 1'b1;
                end else begin
                    m_lat = 2 * W + 1;
                    p_q = bus.dividend / bus.divisor;
                    p_r = bus.dividend % bus.divisor;
                    m_dbz = 1'b0;
                end
                if (m_cyc == m_lat) begin m_q = p_q; m_r = p_r; end
            end
        end else if (m_cyc == m_lat) begin
            m_act = 1'b0;
        end else begin
            m_cyc++;
            if (m_cyc == m_lat) begin m_q = p_q; m_r = p_r; end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy", bus.busy, m_act);
            chk("m_done", bus.done, m_act && (m_cyc == m_lat));
            chk("m_quotient", bus.quotient, m_q);
            chk("m_remainder", bus.remainder, m_r);
            chk("m_dbz", bus.div_by_zero, m_dbz);
        end
    end

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int eq, input int er, input int edz, input int elat,
                           input string tag);
        int n;
        int nbusy;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1; nbusy = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) nbusy++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, elat);
        chk({tag, "_busy_cycles"}, nbusy, elat - 1);
        chk({tag, "_quotient"}, bus.quotient, eq);
        chk({tag, "_remainder"}, bus.remainder, er);
        chk({tag, "_dbz"}, bus.div_by_zero, edz);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        int ops;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_div(4'd13, 4'd3, 4, 1, 0, 9, "d13_3");
        run_div(4'd5, 4'd7, 0, 5, 0, 9, "d5_7");
        run_div(4'd15, 4'd1, 15, 0, 0, 9, "d15_1");
        run_div(4'd9, 4'd0, 15, 9, 1, 1, "d9_0");
        run_div(4'd6, 4'd2, 3, 0, 0, 9, "d6_2");

        // start held, operands changed mid-run
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd14; bus.divisor = 4'd4;
        @(negedge clk);
        bus.dividend = 4'd2; bus.divisor = 4'd1;
        n = 1;
        while (!bus.done && n < 40) begin @(negedge clk); n++; end
        chk("hold_latency", n, 9);
        chk("hold_quotient", bus.quotient, 3);
        chk("hold_remainder", bus.remainder, 2);
        @(negedge clk);
        chk("hold_idle_busy", bus.busy, 0);
        @(negedge clk);
        chk("hold_reaccept_busy", bus.busy, 1);
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 40) begin @(negedge clk); n++; end
        chk("hold2_latency", n, 9);
        chk("hold2_quotient", bus.quotient, 2);
        chk("hold2_remainder", bus.remainder, 0);
        @(negedge clk);

        // reset in cycle 4 of a 12/5 run
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'd12; bus.divisor = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (n < 4) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_quotient", bus.quotient, 0);
        chk("abort_remainder", bus.remainder, 0);
        chk("abort_dbz", bus.div_by_zero, 0);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin @(negedge clk); if (bus.done) seen++; end
        chk("abort_no_done", seen, 0);
        run_div(4'd12, 4'd5, 2, 2, 0, 9, "d12_5");

        // exhaustive back-to-back sweep, checked by the model
        ops = 0;
        bus.start = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                bus.dividend = W'(a);
                bus.divisor  = W'(b);
                @(negedge clk);
                n = 1;
                while (!bus.done && n < 40) begin @(negedge clk); n++; end
                if (bus.done) ops++;
                else chk("sweep_timeout", n, 0);
            end
        end
        bus.start = 1'b0;
        chk("sweep_ops", ops, 256);
        repeat (3) @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
